// File: rtl/ws2812_pkg.sv
// Shared constants and FSM state type for the WS2812B frame path.
// Used by the pROM frame fetcher and the bit serializer.
package ws2812_pkg;
    localparam int BYTES_PER_LED = 3;
    localparam int NUM_LEDS      = 64;
    localparam int FRAME_BYTES   = NUM_LEDS * BYTES_PER_LED;
    localparam int NUM_FRAMES    = 10;
    localparam int FRAME_BASE    = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;
endpackage

// File: rtl/byte_fifo2.sv
// Two-entry FIFO carrying a stream byte plus its last-of-frame tag.
// Push while full is accepted only together with a pop.
module byte_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/prom_frame_fetcher.sv
// Streams stored GRB frames from the pattern pROM to the serializer,
// hiding the ROM's one-cycle read latency behind a 2-entry buffer.
module prom_frame_fetcher #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int NUM_LEDS   = ws2812_pkg::NUM_LEDS,
    parameter int NUM_FRAMES = ws2812_pkg::NUM_FRAMES,
    parameter int FRAME_BASE = ws2812_pkg::FRAME_BASE,
    parameter int IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              prom_ce,
    output logic              prom_oce,
    output logic [ADDR_W-1:0] prom_ad,
    input  logic [DATA_W-1:0] prom_dout,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy,
    output logic              frame_done,
    output logic [IDX_W-1:0]  frame_idx
);
    import ws2812_pkg::*;

    localparam int FB    = NUM_LEDS * BYTES_PER_LED;
    localparam int CNT_W = $clog2(FB + 1);
    localparam logic [CNT_W-1:0]  FB_C    = CNT_W'(FB);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(FB - 1);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(FB);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_FRAMES - 1);

    if (FRAME_BASE + NUM_FRAMES * FB > (1 << ADDR_W)) begin : g_rom_overflow
        $error("frame table does not fit in the ROM address space");
    end

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pending_q, pend_last_q;
    logic              pend_last_d;
    logic              done_d;
    logic              issue;
    logic              pop;
    logic [2:0]        occ;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W:0]   fifo_head;

    byte_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pending_q),
        .push_data ({pend_last_q, prom_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign byte_valid = !fifo_empty;
    assign byte_data  = fifo_head[DATA_W-1:0];
    assign byte_last  = fifo_head[DATA_W];
    assign pop        = byte_valid && byte_ready;
    // Occupancy after this edge, counting the read already in flight.
    assign occ        = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, pending_q};
    assign issue      = (state_q == FETCH) && (cnt_q < FB_C) && (occ < 3'd2);
    assign prom_ce    = issue;
    assign prom_oce   = 1'b1;
    assign prom_ad    = addr_q;
    assign busy       = (state_q != IDLE);
    assign frame_idx  = idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        base_d      = base_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        pend_last_d = issue && (cnt_q == LAST_C);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    addr_d  = base_q;
                end
            end
            FETCH: begin
                if (issue) begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (cnt_q == LAST_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && byte_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (idx_q == IDX_MAX) begin
                        idx_d  = '0;
                        base_d = BASE_C;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        base_d = base_q + STEP_C;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= BASE_C;
            base_q      <= BASE_C;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            pending_q   <= issue;
            pend_last_q <= pend_last_d;
            frame_done  <= done_d;
        end
    end
endmodule

// File: tb/tb_prom_frame_fetcher.sv
// Directed bench for prom_frame_fetcher against a behavioural pROM
// holding addr[7:0]^8'h5A.
module tb_prom_frame_fetcher;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        prom_ce;
    logic        prom_oce;
    logic [10:0] prom_ad;
    logic [7:0]  prom_dout;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;
    logic        frame_done;
    logic [3:0]  frame_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prom_frame_fetcher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prom_ce    (prom_ce),
        .prom_oce   (prom_oce),
        .prom_ad    (prom_ad),
        .prom_dout  (prom_dout),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_idx  (frame_idx)
    );

    function automatic logic [7:0] rom_val(input logic [10:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (prom_ce) prom_dout <= rom_val(prom_ad);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int mode;
        int poke;
        int exp_idx;
        int exp_base;
    } vec_t;

    vec_t tbl [11];

    // mode 0: ready high, 1: random ready, 2: 6-cycle stall at start
    task automatic run_frame(input int mode, input int poke,
                             input int exp_idx, input int exp_base,
                             input int abort_at);
        int n, issued, first_v, last_hs, done_k;
        int viol, stab, dmis, amis, lmis;
        logic pv, pr, pl, fin;
        logic [7:0] pd;
        n = 0; issued = 0; first_v = -1; last_hs = -1; done_k = -1;
        viol = 0; stab = 0; dmis = 0; amis = 0; lmis = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
        chk("idle_idx", frame_idx, exp_idx);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b1;
        byte_ready = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            if (byte_valid && first_v < 0) first_v = k;
            if (pv && !pr) begin
                if (!byte_valid || byte_data !== pd || byte_last !== pl)
                    stab++;
            end
            if (prom_ce) begin
                if (issued - n - int'(byte_valid && byte_ready) >= 2) viol++;
                if (prom_ad !== 11'(exp_base + issued)) amis++;
                issued++;
            end
            if (byte_valid && byte_ready) begin
                if (byte_data !== rom_val(11'(exp_base + n))) dmis++;
                if (byte_last !== (n == 191)) lmis++;
                n++;
                if (n == 192) last_hs = k;
            end
            if (mode == 2 && k == 6) begin
                chk("stall_issued", issued, 2);
                chk("stall_valid", byte_valid, 1);
                chk("stall_data", byte_data, rom_val(11'(exp_base)));
            end
            if (frame_done) begin
                done_k = k;
                chk("done_busy", busy, 0);
                chk("done_idx", frame_idx, (exp_idx + 1) % 10);
                fin = 1'b1;
            end
            pv = byte_valid; pr = byte_ready; pd = byte_data; pl = byte_last;
            if (abort_at >= 0 && n == abort_at) begin
                chk("pending_at_abort", issued > n, 1);
                return;
            end
            if (fin) break;
            @(posedge clk); #1;
            case (mode)
                1:       byte_ready = 1'($urandom_range(0, 1));
                2:       byte_ready = (k >= 6);
                default: byte_ready = 1'b1;
            endcase
            start = (poke > 0 && k == poke);
        end
        chk("done_seen", done_k > 0, 1);
        chk("byte_count", n, 192);
        chk("data_mismatches", dmis, 0);
        chk("last_mismatches", lmis, 0);
        chk("addr_mismatches", amis, 0);
        chk("issue_violations", viol, 0);
        chk("stall_instability", stab, 0);
        chk("first_valid_cycle", first_v, 3);
        chk("done_after_last", done_k, last_hs + 1);
        if (mode == 0) chk("frame_cycles", done_k, 195);
        @(negedge clk);
        chk("done_pulse_width", frame_done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 192};
        tbl[2]  = '{1, 0, 2, 384};
        tbl[3]  = '{2, 0, 3, 576};
        tbl[4]  = '{0, 50, 4, 768};
        tbl[5]  = '{1, 0, 5, 960};
        tbl[6]  = '{0, 0, 6, 1152};
        tbl[7]  = '{0, 0, 7, 1344};
        tbl[8]  = '{0, 0, 8, 1536};
        tbl[9]  = '{0, 0, 9, 1728};
        tbl[10] = '{0, 0, 0, 0};

        reset = 1'b1;
        start = 1'b0;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ce", prom_ce, 0);
        chk("rst_oce", prom_oce, 1);
        chk("rst_ad", prom_ad, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_idx", frame_idx, 0);

        for (int i = 0; i < 11; i++)
            run_frame(tbl[i].mode, tbl[i].poke, tbl[i].exp_idx,
                      tbl[i].exp_base, -1);

        run_frame(0, 0, 1, 192, 100);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", byte_valid, 0);
        chk("mid_rst_ce", prom_ce, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_idx", frame_idx, 0);
        chk("mid_rst_ad", prom_ad, 0);
        begin
            int stale;
            stale = 0;
            repeat (5) begin
                @(negedge clk);
                if (byte_valid || frame_done || prom_ce) stale++;
            end
            chk("post_rst_quiet", stale, 0);
        end
        run_frame(0, 0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prom_frame_fetcher.md
Name: prom_frame_fetcher

Overview:
Sequencer that reads stored GRB pixel frames out of the 2048x8 pattern pROM and streams them one byte at a time to the WS2812B bit serializer. Each frame is a contiguous block of NUM_LEDS*3 bytes in the ROM. The block drives the ROM's ce/oce/ad pins and absorbs the ROM's 1-cycle read latency. It presents bytes on a valid/ready stream with a 2-entry buffer, so backpressure never loses a byte.

Parameters:
ADDR_W, 11, ROM address width (2048 bytes)
DATA_W, 8, ROM and stream byte width
NUM_LEDS, 64, LEDs per strip; FRAME_BYTES = NUM_LEDS*3 = 192
NUM_FRAMES, 10, frames stored back to back; elaboration check requires FRAME_BASE + NUM_FRAMES*FRAME_BYTES <= 2**ADDR_W
FRAME_BASE, 0, ROM byte address of frame 0

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high
start  in  1  request playout of the next frame; sampled only in IDLE
prom_ce  out  1  ROM read enable, high exactly on cycles a read is issued
prom_oce  out  1  ROM output enable, constant 1
prom_ad  out  ADDR_W  ROM byte address
prom_dout  in  DATA_W  ROM read data, valid the cycle after prom_ce
byte_data  out  DATA_W  stream byte (G,R,B order per LED as stored)
byte_valid  out  1  stream valid
byte_ready  in  1  stream ready from serializer
byte_last  out  1  qualifies the final byte of the frame
busy  out  1  high from start acceptance until the last byte handshakes
frame_done  out  1  1-cycle pulse the cycle after the last-byte handshake
frame_idx  out  clog2(NUM_FRAMES)  index of current/next frame

Behaviour:
- Reset values: prom_ce=0, prom_ad=FRAME_BASE, byte_valid=0, byte_last=0, busy=0, frame_done=0, frame_idx=0, FIFO empty, pending=0, state IDLE. prom_oce=1 always.
- States: IDLE, FETCH, DRAIN.
- IDLE, start=1: go to FETCH, busy=1, byte_cnt=0, addr=frame_base_reg.
- FETCH issue rule: issue when byte_cnt<FRAME_BYTES and (fifo_count - pop + pending) < 2, where pop = byte_valid & byte_ready.
  - On issue: prom_ce=1, prom_ad=frame_base_reg+byte_cnt, byte_cnt++, pending<=1; else pending<=0.
  - Data capture: when pending=1, push prom_dout into the FIFO at the next edge. The push is unconditional; the issue rule guarantees space.
  - When byte_cnt reaches FRAME_BYTES, go to DRAIN.
- DRAIN: wait for the FIFO to empty and pending=0. On the handshake of the byte tagged last, go to IDLE, busy=0, frame_done=1 for 1 cycle, and advance the frame.
- Frame advance: frame_idx++ and frame_base_reg+=FRAME_BYTES. After NUM_FRAMES-1, wrap to frame_idx=0 and frame_base_reg=FRAME_BASE.
- byte_last: a tag bit is stored with each FIFO entry, set for byte_cnt==FRAME_BYTES-1. byte_last is meaningful only while byte_valid=1.
- Latency: first byte_valid is high 3 cycles after the cycle start is sampled. With byte_ready held high, throughput is 1 byte/cycle, and a 192-byte frame completes in 192+3 cycles.
- Stream rules: byte_data and byte_last hold stable while byte_valid=1 and byte_ready=0. byte_valid never drops without a handshake.
- start while busy: ignored; not queued. start in the same cycle as frame_done is honoured only if state is already IDLE.
- Reset mid-frame: FIFO flushed, any in-flight read discarded, frame_idx returns to 0, no frame_done.
- Address arithmetic: ADDR_W-bit unsigned; the elaboration check guarantees no overflow.

Decomposition:
- Shared package ws2812_pkg: BYTES_PER_LED=3, NUM_LEDS, FRAME_BYTES, NUM_FRAMES, FRAME_BASE, and a state enum {IDLE,FETCH,DRAIN}. The serializer uses the same package.
- One sub-module, byte_fifo2: 2-entry FIFO of DATA_W+1 bits (data+last) with push, pop, count, empty, full. It is synchronous-reset to empty and supports simultaneous push/pop at count 1 and 2.

Test Plan:
- ROM model loaded with addr[7:0]^0x5A; start pulse with ready=1 -> 192 bytes equal model[0..191] in order, byte_last only on byte 191, first valid 3 cycles after start, frame_done 1 cycle after byte 191, busy low after.
- Random byte_ready (50% duty), 3 frames -> no lost or duplicated bytes, prom_ce never issued with fifo_count+pending=2, data stable under stall.
- byte_ready low for 6 cycles immediately after first issue -> FIFO holds exactly 2 bytes, prom_ce stays 0 during stall, stream resumes with correct bytes.
- 11 consecutive frames -> frame_idx 0..9 then 0, frame 10 addresses start at 0 (frame 9 starts at 1728).
- start pulsed at byte 50 of a frame -> ignored; frame_idx increments once; exactly 192 bytes emitted.
- reset asserted at byte 100 with a read pending -> all outputs at reset values next cycle, no stale byte_valid; following start streams frame 0 from address 0.
